// File: rtl/spi_rx_deframer.sv
// SPI receive deframer: validates header/length/checksum and exposes only committed
// payload words through a first-word-fall-through buffer with speculative write pointer.
module spi_rx_deframer #(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DISCARD} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [15:0]   r_sum, w_sum_nxt;
    logic [PW-1:0] r_wr_spec, w_spec_nxt;
    logic [PW-1:0] r_wr_commit, w_commit_nxt;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ok, r_err, r_ovf;
    logic          w_ok_nxt, w_err_nxt, w_ovf_nxt;
    logic          r_ss_s1, r_ss_s2, r_ss_s3;
    logic [16:0]   r_mem [DEPTH];

    logic          w_abort, w_full, w_pop, w_hdr_ok, w_we;
    logic [16:0]   w_wdata;

    // r_ss_s3 only remembers the previous synchronised level for edge detection
    assign w_abort  = r_ss_s2 & ~r_ss_s3;
    assign w_full   = (r_wr_spec[AW] != r_rd_ptr[AW]) &&
                      (r_wr_spec[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = out_valid & out_ready;
    assign w_hdr_ok = (word_data[15:8] == 8'hA5) && (word_data[7:0] != 8'd0) &&
                      (word_data[7:0] <= 8'(MAX_LEN));
    assign w_wdata  = {(r_cnt == 8'd1), word_data};

    assign out_valid = (r_rd_ptr != r_wr_commit);
    assign out_data  = r_mem[r_rd_ptr[AW-1:0]][15:0];
    assign out_last  = r_mem[r_rd_ptr[AW-1:0]][16];
    assign pkt_ok    = r_ok;
    assign pkt_err   = r_err;
    assign overflow  = r_ovf;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sum_nxt    = r_sum;
        w_spec_nxt   = r_wr_spec;
        w_commit_nxt = r_wr_commit;
        w_ok_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_ovf_nxt    = 1'b0;
        w_we         = 1'b0;
        if (r_state == IDLE) begin
            if (word_valid) begin
                if (w_hdr_ok) begin
                    w_cnt_nxt   = word_data[7:0];
                    w_sum_nxt   = 16'd0;
                    w_state_nxt = PAYLOAD;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
        end else if (w_abort) begin
            w_spec_nxt  = r_wr_commit;
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
        end else if (word_valid) begin
            case (r_state)
                PAYLOAD: begin
                    if (w_full) begin
                        // r_cnt-1 payload words remain plus the checksum word
                        w_spec_nxt  = r_wr_commit;
                        w_err_nxt   = 1'b1;
                        w_ovf_nxt   = 1'b1;
                        w_state_nxt = DISCARD;
                    end else begin
                        w_we       = 1'b1;
                        w_spec_nxt = r_wr_spec + 1'b1;
                        w_sum_nxt  = r_sum + word_data;
                        w_cnt_nxt  = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (word_data == r_sum) begin
                        w_commit_nxt = r_wr_spec;
                        w_ok_nxt     = 1'b1;
                    end else begin
                        w_spec_nxt = r_wr_commit;
                        w_err_nxt  = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end
                DISCARD: begin
                    if (r_cnt == 8'd1) w_state_nxt = IDLE;
                    else               w_cnt_nxt   = r_cnt - 8'd1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_ss_s1     <= 1'b1;
            r_ss_s2     <= 1'b1;
            r_ss_s3     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sum       <= w_sum_nxt;
            r_wr_spec   <= w_spec_nxt;
            r_wr_commit <= w_commit_nxt;
            r_ok        <= w_ok_nxt;
            r_err       <= w_err_nxt;
            r_ovf       <= w_ovf_nxt;
            r_ss_s1     <= SS_n;
            r_ss_s2     <= r_ss_s1;
            r_ss_s3     <= r_ss_s2;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_spec[AW-1:0]] <= w_wdata;
    end
endmodule

// File: tb/tb_spi_rx_deframer.sv
// Scoreboard bench for spi_rx_deframer: a packet-level model predicts pulses and
// committed words; a negedge monitor checks everything the DUT presents.
module tb_spi_rx_deframer;
    localparam int DEPTH   = 64;
    localparam int MAX_LEN = 32;
    localparam logic [2:0] E_OK = 3'b001, E_ERR = 3'b010, E_OVF = 3'b110;

    logic        clk = 1'b0, rst_n = 1'b0, SS_n = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word_data = 16'h0;
    logic        out_valid, out_last, out_ready;
    logic [15:0] out_data;
    logic        pkt_ok, pkt_err, overflow;
    logic        rand_rdy = 1'b0, fix_rdy = 1'b1, rr = 1'b1;

    int checks = 0, errors = 0;
    int occ = 0;
    logic [16:0] exp_words[$];
    logic [2:0]  exp_evt[$];
    logic [15:0] pl[$];

    assign out_ready = rand_rdy ? rr : fix_rdy;

    spi_rx_deframer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .word_valid(word_valid),
        .word_data(word_data), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .pkt_ok(pkt_ok),
        .pkt_err(pkt_err), .overflow(overflow));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rr = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: every pop and every pulse is matched against the model queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_words.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got %h expected none", {out_last, out_data});
                end else begin
                    logic [16:0] e;
                    e = exp_words.pop_front();
                    occ--;
                    if ({out_last, out_data} !== e) begin
                        errors++;
                        $display("FAIL pop_data got %h expected %h", {out_last, out_data}, e);
                    end
                end
            end
            if (pkt_ok || pkt_err || overflow) begin
                checks++;
                if (exp_evt.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected got %b expected none", {overflow, pkt_err, pkt_ok});
                end else begin
                    logic [2:0] e;
                    e = exp_evt.pop_front();
                    if ({overflow, pkt_err, pkt_ok} !== e) begin
                        errors++;
                        $display("FAIL evt_code got %b expected %b", {overflow, pkt_err, pkt_ok}, e);
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [15:0] w);
        word_valid = 1'b1;
        word_data  = w;
        @(posedge clk); #1;
        word_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic do_abort();
        SS_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 SS_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // chk_val < 0 sends the correct checksum; abort_at in [0..n] raises SS_n
    // before payload word abort_at (n = while waiting for the checksum)
    task automatic send_pkt(input logic [15:0] hdr, input int chk_val, input int abort_at);
        int n;
        bit drop;
        logic [15:0] s, c;
        logic [16:0] acc[$];
        n = int'(hdr[7:0]);
        if (hdr[15:8] != 8'hA5 || n == 0 || n > MAX_LEN) begin
            exp_evt.push_back(E_ERR);
            send_word(hdr);
            return;
        end
        send_word(hdr);
        s = 16'h0;
        drop = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (abort_at == i) begin
                exp_evt.push_back(E_ERR);
                do_abort();
                return;
            end
            if (!drop && (occ + i >= DEPTH)) begin
                drop = 1'b1;
                exp_evt.push_back(E_OVF);
            end
            if (!drop) begin
                s = s + pl[i];
                acc.push_back({(i == n - 1), pl[i]});
            end
            send_word(pl[i]);
        end
        if (abort_at == n) begin
            exp_evt.push_back(E_ERR);
            do_abort();
            return;
        end
        c = (chk_val < 0) ? s : 16'(chk_val);
        if (!drop) begin
            if (c == s) begin
                exp_evt.push_back(E_OK);
                foreach (acc[j]) exp_words.push_back(acc[j]);
                occ += n;
            end else begin
                exp_evt.push_back(E_ERR);
            end
        end
        send_word(c);
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        while ((exp_words.size() != 0 || exp_evt.size() != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk({nm, "_drain"}, 32'(exp_words.size() + exp_evt.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_pl(input int n, input bit rnd, input int base);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(rnd ? 16'($urandom) : 16'(base + i));
    endtask

    initial begin
        fix_rdy = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pulses", {29'd0, overflow, pkt_err, pkt_ok}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic 3-word packet
        pl = '{16'h0001, 16'h0002, 16'h0003};
        send_pkt(16'hA503, 16'h0006, -1);
        wait_drain("basic");

        // bad checksum, nothing visible
        fix_rdy = 1'b0;
        pl = '{16'h1111, 16'h2222};
        send_pkt(16'hA502, 16'h0000, -1);
        repeat (3) @(posedge clk); #1;
        chk("badsum_no_valid", {31'd0, out_valid}, 32'd0);
        fix_rdy = 1'b1;
        wait_drain("badsum");

        // bad headers then a good packet
        send_pkt(16'h5A02, -1, -1);
        send_pkt(16'hA500, -1, -1);
        send_pkt(16'hA521, -1, -1);
        fill_pl(2, 1'b0, 16'h0040);
        send_pkt(16'hA502, -1, -1);
        wait_drain("badhdr");

        // overflow: two full-size packets fill the buffer, third is dropped
        fix_rdy = 1'b0;
        fill_pl(32, 1'b0, 16'h0100);
        send_pkt(16'hA520, -1, -1);
        fill_pl(32, 1'b0, 16'h0200);
        send_pkt(16'hA520, -1, -1);
        fill_pl(32, 1'b0, 16'h0300);
        send_pkt(16'hA520, -1, -1);
        repeat (3) @(posedge clk); #1;
        chk("ovf_still_valid", {31'd0, out_valid}, 32'd1);
        chk("ovf_head", {15'd0, out_last, out_data}, 32'h0000_0100);
        fix_rdy = 1'b1;
        wait_drain("ovf");

        // abort mid-payload then a good packet
        fix_rdy = 1'b0;
        fill_pl(4, 1'b0, 16'h0500);
        send_pkt(16'hA504, -1, 2);
        chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
        fix_rdy = 1'b1;
        fill_pl(4, 1'b0, 16'h0600);
        send_pkt(16'hA504, -1, -1);
        wait_drain("abort");

        // reset while a packet is in progress with a committed one unread
        fix_rdy = 1'b0;
        fill_pl(3, 1'b0, 16'h0700);
        send_pkt(16'hA503, -1, -1);
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        send_word(16'hA504);
        send_word(16'h0011);
        send_word(16'h0022);
        chk("pre_rst_evt_seen", 32'(exp_evt.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        exp_words.delete();
        exp_evt.delete();
        occ = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("postrst_valid", {31'd0, out_valid}, 32'd0);
        chk("postrst_pulses", {29'd0, overflow, pkt_err, pkt_ok}, 32'd0);
        fix_rdy = 1'b1;

        // randomized traffic
        rand_rdy = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int kind, n;
            kind = $urandom_range(0, 9);
            n = $urandom_range(1, MAX_LEN);
            fill_pl(n, 1'b1, 0);
            case (kind)
                0: begin
                    case ($urandom_range(0, 2))
                        0: send_pkt({8'h5A, 8'(n)}, -1, -1);
                        1: send_pkt(16'hA500, -1, -1);
                        default: send_pkt({8'hA5, 8'($urandom_range(MAX_LEN + 1, 255))}, -1, -1);
                    endcase
                end
                1: send_pkt({8'hA5, 8'(n)}, int'($urandom_range(0, 65535)), -1);
                2: send_pkt({8'hA5, 8'(n)}, -1, $urandom_range(0, n));
                default: send_pkt({8'hA5, 8'(n)}, -1, -1);
            endcase
        end
        rand_rdy = 1'b0;
        fix_rdy = 1'b1;
        wait_drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
